// File: rtl/wb_cache_pkg.sv
// Shared types and address helpers for the Wishbone exmem read cache.
// The address helpers take the index width as an argument so one package serves any LINES.
package wb_cache_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR_THRU = 2'd2,
      RESP    = 2'd3
   } state_e;

   localparam int             CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Word index of a byte address; caller truncates to its index width.
   function automatic logic [31:0] addr_idx(input logic [31:0] adr, input int idx_bits);
      return (adr >> 2) & ((32'd1 << idx_bits) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_tag(input logic [31:0] adr, input int idx_bits);
      return adr >> (idx_bits + 2);
   endfunction

endpackage

// File: rtl/wb_cache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: one combinational read port,
// one byte-masked write port and a flush-all that overrides any same-cycle write.
module wb_cache_line_array
   import wb_cache_pkg::*;
#(
   parameter int LINES    = 8,
   parameter int IDX_BITS = $clog2(LINES),
   parameter int TAG_BITS = 30 - IDX_BITS
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic [IDX_BITS-1:0] rd_idx_i,
   output logic                rd_valid_o,
   output logic [TAG_BITS-1:0] rd_tag_o,
   output logic [31:0]         rd_data_o,
   input  logic                wr_en_i,
   input  logic [IDX_BITS-1:0] wr_idx_i,
   input  logic [TAG_BITS-1:0] wr_tag_i,
   input  logic [3:0]          wr_be_i,
   input  logic [31:0]         wr_data_i
);

   logic [LINES-1:0]    valid_q;
   logic [TAG_BITS-1:0] tag_q [LINES];

   generate
      for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               valid_q[gi] <= 1'b0;
            end else if (flush_i) begin
               valid_q[gi] <= 1'b0;
            end else if (wr_en_i && (wr_idx_i == IDX_BITS'(gi))) begin
               valid_q[gi] <= 1'b1;
            end
         end
      end

      // One storage array per byte lane keeps the masked write single-driver.
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_q [LINES];
         always_ff @(posedge clk_i) begin
            if (wr_en_i && wr_be_i[gi]) begin
               lane_q[wr_idx_i] <= wr_data_i[gi*8 +: 8];
            end
         end
         assign rd_data_o[gi*8 +: 8] = lane_q[rd_idx_i];
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_q[wr_idx_i] <= wr_tag_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];

endmodule

// File: rtl/wb_exmem_read_cache.sv
// Direct-mapped write-through read cache in front of the exmem Wishbone slave.
// Read hits answer in one cycle; misses and writes go downstream one at a time.
module wb_exmem_read_cache
   import wb_cache_pkg::*;
#(
   parameter int LINES    = 8,
   parameter int IDX_BITS = $clog2(LINES),
   parameter int TAG_BITS = 30 - IDX_BITS
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [3:0]       wbm_sel_o,
   output logic [31:0]      wbm_adr_o,
   output logic [31:0]      wbm_dat_o,
   input  logic             wbm_ack_i,
   input  logic [31:0]      wbm_dat_i,
   input  logic             flush_i,
   output logic [CNT_W-1:0] hit_cnt_o,
   output logic [CNT_W-1:0] miss_cnt_o
);

   state_e           state_q, state_d;
   logic [31:0]      adr_q, dat_q, resp_dat_q;
   logic [3:0]       sel_q;
   logic             abort_q;
   logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

   logic                req, accept, active, hit;
   logic [IDX_BITS-1:0] idx_up, idx_q, rd_idx;
   logic [TAG_BITS-1:0] tag_up, tag_q, tag_cmp;
   logic                rd_valid;
   logic [TAG_BITS-1:0] rd_tag;
   logic [31:0]         rd_data;
   logic                arr_we;
   logic [3:0]          arr_be;
   logic [31:0]         arr_data;

   assign req     = wbs_cyc_i & wbs_stb_i;
   assign accept  = (state_q == IDLE) & req & ~wbs_ack_o;
   assign active  = (state_q == RD_MISS) | (state_q == WR_THRU);
   assign idx_up  = IDX_BITS'(addr_idx(wbs_adr_i, IDX_BITS));
   assign tag_up  = TAG_BITS'(addr_tag(wbs_adr_i, IDX_BITS));
   assign idx_q   = IDX_BITS'(addr_idx(adr_q, IDX_BITS));
   assign tag_q   = TAG_BITS'(addr_tag(adr_q, IDX_BITS));
   // Lookup uses the live request in IDLE and the captured address while downstream is busy.
   assign rd_idx  = (state_q == IDLE) ? idx_up : idx_q;
   assign tag_cmp = (state_q == IDLE) ? tag_up : tag_q;
   assign hit     = rd_valid & (rd_tag == tag_cmp);

   wb_cache_line_array #(
      .LINES   (LINES),
      .IDX_BITS(IDX_BITS),
      .TAG_BITS(TAG_BITS)
   ) u_lines (
      .clk_i     (wb_clk_i),
      .rst_i     (wb_rst_i),
      .flush_i   (flush_i),
      .rd_idx_i  (rd_idx),
      .rd_valid_o(rd_valid),
      .rd_tag_o  (rd_tag),
      .rd_data_o (rd_data),
      .wr_en_i   (arr_we),
      .wr_idx_i  (idx_q),
      .wr_tag_i  (tag_q),
      .wr_be_i   (arr_be),
      .wr_data_i (arr_data)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (wbs_we_i)  state_d = WR_THRU;
               else if (hit)  state_d = RESP;
               else           state_d = RD_MISS;
            end
         end
         RD_MISS, WR_THRU: begin
            if (wbm_ack_i) state_d = (abort_q | ~req) ? IDLE : RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wbm_cyc_o = active;
      wbm_stb_o = active;
      wbm_we_o  = (state_q == WR_THRU);
      wbm_sel_o = 4'h0;
      wbm_adr_o = active ? adr_q : 32'h0;
      wbm_dat_o = (state_q == WR_THRU) ? dat_q : 32'h0;
      if (state_q == RD_MISS)      wbm_sel_o = 4'hF;
      else if (state_q == WR_THRU) wbm_sel_o = sel_q;
      // A write miss leaves the array untouched; a write hit merges only the selected bytes.
      arr_we    = wbm_ack_i & ((state_q == RD_MISS) | ((state_q == WR_THRU) & hit));
      arr_be    = (state_q == RD_MISS) ? 4'hF : sel_q;
      arr_data  = (state_q == RD_MISS) ? wbm_dat_i : dat_q;
      wbs_ack_o = (state_q == RESP);
      wbs_dat_o = wbs_ack_o ? resp_dat_q : 32'h0;
      hit_cnt_o  = hit_cnt_q;
      miss_cnt_o = miss_cnt_q;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         adr_q      <= 32'h0;
         dat_q      <= 32'h0;
         sel_q      <= 4'h0;
         abort_q    <= 1'b0;
         resp_dat_q <= 32'h0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (accept) begin
            adr_q   <= wbs_adr_i;
            dat_q   <= wbs_dat_i;
            sel_q   <= wbs_sel_i;
            abort_q <= 1'b0;
            if (!wbs_we_i) begin
               if (hit) begin
                  resp_dat_q <= rd_data;
                  if (hit_cnt_q != CNT_MAX) hit_cnt_q <= hit_cnt_q + 1'b1;
               end else if (miss_cnt_q != CNT_MAX) begin
                  miss_cnt_q <= miss_cnt_q + 1'b1;
               end
            end
         end
         if (active && !req) abort_q <= 1'b1;
         if ((state_q == RD_MISS) && wbm_ack_i) resp_dat_q <= wbm_dat_i;
      end
   end

endmodule

// File: tb/tb_wb_exmem_read_cache.sv
// Randomised bench for wb_exmem_read_cache with a word-level cache/memory reference model
// and a variable-latency exmem slave model.
module tb_wb_exmem_read_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic        wbs_cyc, wbs_stb, wbs_we;
   logic [3:0]  wbs_sel;
   logic [31:0] wbs_adr, wbs_dat;
   logic        wbs_ack;
   logic [31:0] wbs_rdat;
   logic        wbm_cyc, wbm_stb, wbm_we;
   logic [3:0]  wbm_sel;
   logic [31:0] wbm_adr, wbm_wdat;
   logic        wbm_ack;
   logic [31:0] wbm_rdat;
   logic        flush;
   logic [15:0] hit_cnt, miss_cnt;

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc_n = 0;
   int last_ack_cyc = 0;
   int ds_rd = 0, ds_wr = 0;
   int proto_err = 0, idle_err = 0;
   int slv_lat = 1;
   bit flush_on_ack = 0, flush_pulse = 0;

   // Reference model: 8 one-word lines over a word-addressed memory.
   bit          ref_valid [8];
   logic [26:0] ref_tag [8];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] slv_mem [logic [31:0]];
   int          m_hits = 0, m_misses = 0;

   wb_exmem_read_cache dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_cyc_i (wbs_cyc),
      .wbs_stb_i (wbs_stb),
      .wbs_we_i  (wbs_we),
      .wbs_sel_i (wbs_sel),
      .wbs_adr_i (wbs_adr),
      .wbs_dat_i (wbs_dat),
      .wbs_ack_o (wbs_ack),
      .wbs_dat_o (wbs_rdat),
      .wbm_cyc_o (wbm_cyc),
      .wbm_stb_o (wbm_stb),
      .wbm_we_o  (wbm_we),
      .wbm_sel_o (wbm_sel),
      .wbm_adr_o (wbm_adr),
      .wbm_dat_o (wbm_wdat),
      .wbm_ack_i (wbm_ack),
      .wbm_dat_i (wbm_rdat),
      .flush_i   (flush),
      .hit_cnt_o (hit_cnt),
      .miss_cnt_o(miss_cnt)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc_n++;
   end

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   // exmem slave model: ack after slv_lat cycles of request, one cycle wide.
   initial begin
      int wait_cnt;
      logic [31:0] wa;
      wait_cnt = 0;
      wbm_ack = 1'b0;
      wbm_rdat = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (wbm_ack) begin
            wbm_ack = 1'b0;
            wbm_rdat = 32'h0;
            if (flush_pulse) begin
               flush = 1'b0;
               flush_pulse = 0;
            end
            if (wbm_cyc) proto_err++;
            wait_cnt = 0;
         end else if (wbm_cyc && wbm_stb && !rst) begin
            wait_cnt++;
            if (wait_cnt >= slv_lat) begin
               wa = {wbm_adr[31:2], 2'b00};
               if (!slv_mem.exists(wa)) slv_mem[wa] = init_val(wa);
               if (wbm_we) begin
                  slv_mem[wa] = merge(slv_mem[wa], wbm_wdat, wbm_sel);
                  ds_wr++;
               end else begin
                  if (wbm_sel != 4'hF) proto_err++;
                  wbm_rdat = slv_mem[wa];
                  ds_rd++;
               end
               wbm_ack = 1'b1;
               last_ack_cyc = cyc_n;
               wait_cnt = 0;
               if (flush_on_ack) begin
                  flush = 1'b1;
                  flush_pulse = 1;
                  flush_on_ack = 0;
               end
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   task automatic model_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, output bit exp_hit, output logic [31:0] exp_dat);
      logic [31:0] wa;
      int i;
      wa = {adr[31:2], 2'b00};
      i = int'(adr[4:2]);
      if (!ref_mem.exists(wa)) ref_mem[wa] = init_val(wa);
      exp_hit = ref_valid[i] && (ref_tag[i] == adr[31:5]);
      exp_dat = 32'h0;
      if (we) begin
         ref_mem[wa] = merge(ref_mem[wa], dat, sel);
      end else begin
         if (exp_hit) m_hits++;
         else begin
            m_misses++;
            ref_valid[i] = 1;
            ref_tag[i] = adr[31:5];
         end
         exp_dat = ref_mem[wa];
      end
   endtask

   task automatic model_flush();
      for (int i = 0; i < 8; i++) ref_valid[i] = 0;
   endtask

   task automatic access(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         output logic [31:0] rdat, output int start_cyc, output int ack_cyc, output bit to);
      @(posedge clk);
      #1;
      wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we;
      wbs_adr = adr; wbs_dat = dat; wbs_sel = sel;
      start_cyc = cyc_n;
      to = 1;
      rdat = 32'h0;
      ack_cyc = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (wbs_ack) begin
            rdat = wbs_rdat;
            ack_cyc = cyc_n;
            to = 0;
            break;
         end
      end
      wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
      @(posedge clk);
      #1;
      if (wbs_ack || wbs_rdat != 32'h0) idle_err++;
      $display("txn we=%0d adr=%08h wdat=%08h sel=%h rdat=%08h lat=%0d to=%0d",
               we, adr, dat, sel, rdat, ack_cyc - start_cyc, to);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbs_sel = 0; wbs_adr = 0; wbs_dat = 0; flush = 0;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if ({wbs_ack, wbs_rdat} !== 33'h0) $display("FAIL reset_up ack=%b dat=%08h want 0/0", wbs_ack, wbs_rdat);
      else pass_cnt++;
      total_cnt++;
      if ({wbm_cyc, wbm_stb, wbm_we, wbm_sel} !== 7'h0) $display("FAIL reset_ctl got %b want 0", {wbm_cyc, wbm_stb, wbm_we, wbm_sel});
      else pass_cnt++;
      total_cnt++;
      if ({wbm_adr, wbm_wdat} !== 64'h0) $display("FAIL reset_adr_dat got %h want 0", {wbm_adr, wbm_wdat});
      else pass_cnt++;
      total_cnt++;
      if ({hit_cnt, miss_cnt} !== 32'h0) $display("FAIL reset_cnt got %h want 0", {hit_cnt, miss_cnt});
      else pass_cnt++;
      rst = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_cold_read();
      logic [31:0] r, e; int s, a, r0; bit to, h;
      ref_mem[32'h3800_0010] = 32'hDEAD_BEEF;
      slv_mem[32'h3800_0010] = 32'hDEAD_BEEF;
      slv_lat = 12;
      model_access(0, 32'h3800_0010, 0, 4'hF, h, e);
      r0 = ds_rd;
      access(0, 32'h3800_0010, 0, 4'hF, r, s, a, to);
      total_cnt++;
      if (to || r !== e) $display("FAIL cold_data got %08h want %08h to=%0d", r, e, to);
      else pass_cnt++;
      total_cnt++;
      if (ds_rd - r0 != 1) $display("FAIL cold_ds_reads got %0d want 1", ds_rd - r0);
      else pass_cnt++;
      total_cnt++;
      if (a != last_ack_cyc + 1) $display("FAIL cold_latency ack cyc %0d want %0d", a, last_ack_cyc + 1);
      else pass_cnt++;
      total_cnt++;
      if (miss_cnt !== 16'd1) $display("FAIL cold_miss_cnt got %0d want 1", miss_cnt);
      else pass_cnt++;
   endtask

   task automatic test_hit();
      logic [31:0] r, e; int s, a, r0; bit to, h;
      model_access(0, 32'h3800_0010, 0, 4'hF, h, e);
      r0 = ds_rd;
      access(0, 32'h3800_0010, 0, 4'hF, r, s, a, to);
      total_cnt++;
      if (to || r !== e) $display("FAIL hit_data got %08h want %08h", r, e);
      else pass_cnt++;
      total_cnt++;
      if (ds_rd != r0 || a - s != 1) $display("FAIL hit_path ds=%0d lat=%0d want 0/1", ds_rd - r0, a - s);
      else pass_cnt++;
      total_cnt++;
      if (hit_cnt !== 16'd1) $display("FAIL hit_cnt got %0d want 1", hit_cnt);
      else pass_cnt++;
   endtask

   task automatic test_write_thru();
      logic [31:0] r, e; int s, a, r0, w0; bit to, h;
      slv_lat = 3;
      model_access(1, 32'h3800_0010, 32'h1122_3344, 4'b0011, h, e);
      w0 = ds_wr;
      access(1, 32'h3800_0010, 32'h1122_3344, 4'b0011, r, s, a, to);
      total_cnt++;
      if (to || ds_wr - w0 != 1) $display("FAIL wr_ds_writes got %0d want 1 to=%0d", ds_wr - w0, to);
      else pass_cnt++;
      model_access(0, 32'h3800_0010, 0, 4'hF, h, e);
      r0 = ds_rd;
      access(0, 32'h3800_0010, 0, 4'hF, r, s, a, to);
      total_cnt++;
      if (r !== 32'hDEAD_3344 || ds_rd != r0) $display("FAIL wr_merge got %08h ds=%0d want dead3344/0", r, ds_rd - r0);
      else pass_cnt++;
   endtask

   task automatic test_conflict();
      logic [31:0] r, e; int s, a, r0, m0; bit to, h;
      logic [31:0] adrs [3];
      adrs[0] = 32'h3800_0000; adrs[1] = 32'h3800_0020; adrs[2] = 32'h3800_0000;
      r0 = ds_rd; m0 = miss_cnt;
      for (int i = 0; i < 3; i++) begin
         model_access(0, adrs[i], 0, 4'hF, h, e);
         access(0, adrs[i], 0, 4'hF, r, s, a, to);
         total_cnt++;
         if (to || r !== e) $display("FAIL conflict_data[%0d] got %08h want %08h", i, r, e);
         else pass_cnt++;
      end
      total_cnt++;
      if (ds_rd - r0 != 3 || int'(miss_cnt) - m0 != 3) $display("FAIL conflict_misses ds=%0d cnt=%0d want 3/3", ds_rd - r0, int'(miss_cnt) - m0);
      else pass_cnt++;
   endtask

   task automatic test_flush();
      logic [31:0] r, e; int s, a, r0; bit to, h;
      model_access(0, 32'h3800_0040, 0, 4'hF, h, e);
      access(0, 32'h3800_0040, 0, 4'hF, r, s, a, to);
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      model_flush();
      model_access(0, 32'h3800_0040, 0, 4'hF, h, e);
      r0 = ds_rd;
      access(0, 32'h3800_0040, 0, 4'hF, r, s, a, to);
      total_cnt++;
      if (to || r !== e || ds_rd - r0 != 1) $display("FAIL flush_reread got %08h ds=%0d want %08h/1", r, ds_rd - r0, e);
      else pass_cnt++;
      // Flush landing on the fill-ack edge must leave the line invalid.
      flush_on_ack = 1;
      model_access(0, 32'h3800_0044, 0, 4'hF, h, e);
      access(0, 32'h3800_0044, 0, 4'hF, r, s, a, to);
      model_flush();
      total_cnt++;
      if (to || r !== e) $display("FAIL flush_fill_data got %08h want %08h", r, e);
      else pass_cnt++;
      model_access(0, 32'h3800_0044, 0, 4'hF, h, e);
      r0 = ds_rd;
      access(0, 32'h3800_0044, 0, 4'hF, r, s, a, to);
      total_cnt++;
      if (ds_rd - r0 != 1) $display("FAIL flush_fill_miss ds=%0d want 1", ds_rd - r0);
      else pass_cnt++;
   endtask

   task automatic test_abort();
      logic [31:0] r, e; int s, a, r0; bit to, h, seen;
      slv_lat = 6;
      model_access(0, 32'h3800_0400, 0, 4'hF, h, e);
      r0 = ds_rd;
      @(posedge clk); #1;
      wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_adr = 32'h3800_0400; wbs_sel = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      wbs_cyc = 0; wbs_stb = 0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (wbs_ack) seen = 1;
      end
      $display("txn abort adr=38000400 ds=%0d ack_seen=%0d", ds_rd - r0, seen);
      total_cnt++;
      if (seen || ds_rd - r0 != 1 || wbm_cyc) $display("FAIL abort ack=%0d ds=%0d cyc=%0d want 0/1/0", seen, ds_rd - r0, wbm_cyc);
      else pass_cnt++;
      model_access(0, 32'h3800_0400, 0, 4'hF, h, e);
      r0 = ds_rd;
      access(0, 32'h3800_0400, 0, 4'hF, r, s, a, to);
      total_cnt++;
      if (to || r !== e || ds_rd != r0) $display("FAIL abort_fill got %08h ds=%0d want %08h/0", r, ds_rd - r0, e);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [31:0] r, e, adr, dat; logic [3:0] sel; logic we;
      int s, a, r0, w0; bit to, h;
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 19) == 0) begin
            @(posedge clk); #1 flush = 1'b1;
            @(posedge clk); #1 flush = 1'b0;
            model_flush();
         end
         we = ($urandom_range(0, 3) == 0);
         adr = 32'h3800_0000 | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
         dat = $urandom;
         sel = 4'($urandom_range(1, 15));
         slv_lat = $urandom_range(1, 4);
         model_access(we, adr, dat, sel, h, e);
         r0 = ds_rd; w0 = ds_wr;
         access(we, adr, dat, sel, r, s, a, to);
         total_cnt++;
         if (to) $display("FAIL rnd_timeout n=%0d adr=%08h no ack within bound", n, adr);
         else if (we && (ds_wr - w0 != 1 || ds_rd != r0))
            $display("FAIL rnd_write n=%0d wr=%0d rd=%0d want 1/0", n, ds_wr - w0, ds_rd - r0);
         else if (!we && r !== e)
            $display("FAIL rnd_data n=%0d adr=%08h got %08h want %08h", n, adr, r, e);
         else if (!we && ds_rd - r0 != (h ? 0 : 1))
            $display("FAIL rnd_hitmiss n=%0d adr=%08h ds=%0d want %0d", n, adr, ds_rd - r0, h ? 0 : 1);
         else if (!we && h && a - s != 1)
            $display("FAIL rnd_hit_lat n=%0d got %0d want 1", n, a - s);
         else if (!we && !h && a != last_ack_cyc + 1)
            $display("FAIL rnd_miss_lat n=%0d got %0d want %0d", n, a, last_ack_cyc + 1);
         else pass_cnt++;
      end
   endtask

   task automatic test_counters();
      total_cnt++;
      if (int'(hit_cnt) != m_hits || int'(miss_cnt) != m_misses)
         $display("FAIL counters got %0d/%0d want %0d/%0d", hit_cnt, miss_cnt, m_hits, m_misses);
      else pass_cnt++;
      total_cnt++;
      if (proto_err != 0 || idle_err != 0) $display("FAIL protocol got %0d/%0d errors want 0/0", proto_err, idle_err);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] r, e; int s, a, r0; bit to, h;
      slv_lat = 12;
      @(posedge clk); #1;
      wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_adr = 32'h3800_0100; wbs_sel = 4'hF;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      total_cnt++;
      if ({wbm_cyc, wbm_stb, wbm_adr, wbs_ack, hit_cnt, miss_cnt} !== 67'h0)
         $display("FAIL reset_mid got cyc=%0d adr=%08h hit=%0d miss=%0d want 0", wbm_cyc, wbm_adr, hit_cnt, miss_cnt);
      else pass_cnt++;
      wbs_cyc = 0; wbs_stb = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      $display("txn reset_mid adr=38000100");
      model_flush();
      m_hits = 0; m_misses = 0;
      model_access(0, 32'h3800_0100, 0, 4'hF, h, e);
      r0 = ds_rd;
      access(0, 32'h3800_0100, 0, 4'hF, r, s, a, to);
      total_cnt++;
      if (to || r !== e || ds_rd - r0 != 1 || miss_cnt !== 16'd1 || hit_cnt !== 16'd0)
         $display("FAIL reset_mid_read got %08h ds=%0d miss=%0d hit=%0d want %08h/1/1/0", r, ds_rd - r0, miss_cnt, hit_cnt, e);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_cold_read();
      test_hit();
      test_write_thru();
      test_conflict();
      test_flush();
      test_abort();
      test_random();
      test_counters();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/wb_exmem_read_cache.md
Name: wb_exmem_read_cache

Overview:
- Direct-mapped, write-through read cache between the management-SoC Wishbone bus and the exmem BRAM slave (user_proj_example).
- The exmem slave takes DELAYS+2 cycles per access; this block hides that latency on repeated reads, e.g. FIR tap/coefficient fetch loops.
- Acts as a Wishbone slave toward the CPU and as a single-outstanding Wishbone master toward exmem.

Parameters:
- LINES, 8, number of one-word cache lines; power of two, at least 2
- IDX_BITS, $clog2(LINES), derived; index width
- TAG_BITS, 30-IDX_BITS, derived; tag width (address bits 31 down to IDX_BITS+2)

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  asynchronous, active-high reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  upstream Wishbone request
- wbs_sel_i  in  4  upstream byte select
- wbs_adr_i, wbs_dat_i  in  32 each  upstream address / write data
- wbs_ack_o  out  1  upstream ack, registered
- wbs_dat_o  out  32  upstream read data, registered; 0 when not acking
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  downstream request
- wbm_sel_o  out  4  downstream byte select
- wbm_adr_o, wbm_dat_o  out  32 each  downstream address / write data
- wbm_ack_i  in  1  downstream ack
- wbm_dat_i  in  32  downstream read data
- flush_i  in  1  invalidate all lines
- hit_cnt_o, miss_cnt_o  out  16 each  saturating read hit / miss counters

Behaviour:
- Reset (async, any state): state IDLE; all valid bits 0; every output 0 (acks, cyc/stb/we, sel, adr, dat, counters). Any in-flight downstream transaction is dropped.
- Request decode: valid = wbs_cyc_i & wbs_stb_i. A request is accepted only in IDLE and only when wbs_ack_o=0.
- Address mapping: idx = adr[IDX_BITS+1:2]; tag = adr[31:IDX_BITS+2]. hit = valid[idx] & tag match.
- FSM states: IDLE, RD_MISS, WR_THRU, RESP.
- IDLE, read hit: capture line data; go to RESP; wbs_ack_o=1 with data in the next cycle (1-cycle latency); hit_cnt +1.
- IDLE, read miss: go to RD_MISS; miss_cnt +1. Next cycle drive wbm_cyc/stb=1, we=0, sel=4'hF, adr=wbs_adr_i.
- RD_MISS: hold master signals stable until wbm_ack_i. On wbm_ack_i:
  - drop cyc/stb the same edge;
  - write wbm_dat_i into the line (tag updated, valid=1);
  - go to RESP; upstream ack and data appear the next cycle.
- IDLE, write: go to WR_THRU; drive wbm we=1 with sel, adr and dat copied from upstream.
- WR_THRU: on wbm_ack_i, if the line hits, update only the bytes whose sel bit is 1. A write miss does not allocate. Then go to RESP.
- RESP: wbs_ack_o=1 for exactly one cycle; return to IDLE. wbs_ack_o is never high for two consecutive cycles.
- Upstream abort: if valid drops while in RD_MISS or WR_THRU, the downstream transaction still completes and the fill/update still happens. The upstream ack is suppressed and the FSM goes straight to IDLE.
- flush_i: sampled every cycle; clears all valid bits on the next edge. If flush coincides with a fill, flush wins and the line ends invalid. The current response is still delivered.
- Counters: saturate at 16'hFFFF with no wrap; only reads are counted.
- Downstream access: exactly one transaction outstanding at a time. The master never issues a request while wbm_ack_i is high.

Decomposition:
- Package wb_cache_pkg holds:
  - state enum (IDLE, RD_MISS, WR_THRU, RESP);
  - CNT_W=16 and CNT_MAX;
  - functions for idx/tag extraction from a 32-bit address.
- One sub-module, wb_cache_line_array: valid/tag/data storage with one combinational read port, one write port with byte mask, and a flush-all input. The FSM and counters stay in the top level.

Test Plan:
- Cold read 0x3800_0010, downstream model with 12-cycle ack returning 0xDEAD_BEEF -> one downstream read; upstream ack 1 cycle after wbm_ack_i with 0xDEAD_BEEF; miss_cnt=1.
- Repeat the same read -> no wbm_cyc_o; ack 1 cycle after the request with 0xDEAD_BEEF; hit_cnt=1.
- Write 0x1122_3344 to 0x3800_0010 with sel=4'b0011, then read -> one downstream write; read hits and returns 0xDEAD_3344.
- Reads of 0x3800_0000 then 0x3800_0020 (same idx, LINES=8), then 0x3800_0000 again -> three misses: conflict eviction.
- Fill a line, pulse flush_i, re-read -> miss and new downstream read. Flush on the fill-ack cycle -> subsequent read still misses.
- Assert wb_rst_i in the middle of RD_MISS -> all outputs 0 immediately; after release the first read misses; counters are 0.
